// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART line reverser.
//   rx_state_t / tx_state_t : receiver and transmitter FSM states
//   phase_t                 : FILL / DRAIN phase of the line (LIFO) mode
//   frame_t                 : one data frame, sized for the widest legal frame;
//                             narrower frames occupy the low bits, upper bits zero
//   bit_reverse()           : reverses the low 'width' bits of a frame
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef logic [MAX_DATA_BITS-1:0] frame_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic       {PH_FILL, PH_DRAIN} phase_t;

  // Reverse the full frame, then shift right so the reversed data lands back in
  // the low 'width' bits (the zero upper bits fall off the bottom).
  function automatic frame_t bit_reverse(input frame_t value, input int unsigned width);
    frame_t full;
    for (int i = 0; i < int'(MAX_DATA_BITS); i++) full[i] = value[MAX_DATA_BITS-1-i];
    return full >> (MAX_DATA_BITS - width);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, start/data/stop FSM, framing check.
// Ports:
//   CP       in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   rx       in   serial input, idle high, asynchronous to CP
//   rx_data  out  received frame, LSB-aligned, upper unused bits zero
//   rx_valid out  one-cycle pulse when a frame with a valid stop bit arrives
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                     CP,
  input  logic                     RST,
  input  logic                     rx,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid
);

  localparam int         CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic             rx_s1, rx_s2, rx_d;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  frame_t           shift;

  // rx_d is the previous synchronised sample, used only for 1->0 detection.
  // Because a start needs a high-to-low edge, a line held low after a framing
  // error cannot re-trigger until it has returned high.
  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; blocking assignments would chain the synchroniser stages.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            // High at mid-start means the falling edge was a glitch.
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s2;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is silently dropped.
            if (rx_s2) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_line_reverser.sv
// UART echo block: receives frames on rx and retransmits them on tx.
//   MODE 0: each byte is sent back with its bit order reversed.
//   MODE 1: bytes collect in a LIFO until DELIM arrives or the LIFO fills, then
//           the line is sent back in reverse byte order (DELIM appended only
//           when the line was ended by DELIM).
// Ports:
//   CP       in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   rx       in   serial input, idle high
//   tx       out  serial output, idle high
//   busy     out  transmitter active, LIFO non-empty or holding register full
//   overflow out  one-cycle pulse for every received byte that is dropped
module uart_line_reverser
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter int                   CLKS_PER_BIT = 104,
  parameter int                   DEPTH        = 16,
  parameter int                   MODE         = 1,
  parameter logic [DATA_BITS-1:0] DELIM        = 8'h0A
) (
  input  logic CP,
  input  logic RST,
  input  logic rx,
  output logic tx,
  output logic busy,
  output logic overflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   LAST_CNT = (PTR_W + 1)'(DEPTH - 1);

  frame_t           rx_data;
  logic             rx_valid;

  frame_t           lifo [DEPTH];
  logic [PTR_W:0]   count;
  phase_t           phase;
  logic             append_delim;
  frame_t           hold_data;
  logic             hold_valid;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  frame_t           tx_shift;

  frame_t           delim_f;
  logic             is_delim;
  logic             push;
  logic [PTR_W-1:0] top_idx;
  logic             next_avail;
  frame_t           next_data;
  logic             take;

  uart_rx_core #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .CP       (CP),
    .RST      (RST),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  assign delim_f  = frame_t'(DELIM);
  assign is_delim = (rx_data == delim_f);
  assign push     = (MODE != 0) && (phase == PH_FILL) && rx_valid && !is_delim;
  assign top_idx  = PTR_W'(count - 1'b1);

  // Next frame the transmitter may start, if any.
  // NOTE: defaults are assigned first so every path drives both outputs and
  // no latch is inferred.
  always_comb begin
    next_avail = 1'b0;
    next_data  = '0;
    if (MODE == 0) begin
      next_avail = hold_valid;
      next_data  = hold_data;
    end else if (phase == PH_DRAIN) begin
      if (count != '0) begin
        next_avail = 1'b1;
        next_data  = lifo[top_idx];
      end else if (append_delim) begin
        next_avail = 1'b1;
        next_data  = delim_f;
      end
    end
  end

  // A frame starts from idle or straight out of the last stop-bit cycle, which
  // gives back-to-back frames with no idle gap.
  assign take = next_avail &&
                ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == FULL_M1));

  assign busy = (tx_state != TX_IDLE) | (count != '0) | hold_valid;

  // NOTE: the LIFO array has no reset; count alone says which entries are
  // live, so the storage can map onto plain RAM.
  always_ff @(posedge CP) begin
    if (push) lifo[count[PTR_W-1:0]] <= rx_data;
  end

  // Buffer control: holding register (MODE 0) or LIFO phase/count (MODE 1).
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      count        <= '0;
      phase        <= PH_FILL;
      append_delim <= 1'b0;
      hold_data    <= '0;
      hold_valid   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (MODE == 0) begin
        if (take) hold_valid <= 1'b0;
        // Full register drops the new byte even if it is emptying this cycle.
        if (rx_valid) begin
          if (hold_valid) begin
            overflow <= 1'b1;
          end else begin
            hold_data  <= bit_reverse(rx_data, DATA_BITS);
            hold_valid <= 1'b1;
          end
        end
      end else begin
        case (phase)
          PH_FILL: begin
            if (rx_valid) begin
              if (is_delim) begin
                phase        <= PH_DRAIN;
                append_delim <= 1'b1;
              end else begin
                count <= count + 1'b1;
                // Filling the last slot flushes the line without a terminator.
                if (count == LAST_CNT) begin
                  phase        <= PH_DRAIN;
                  append_delim <= 1'b0;
                end
              end
            end
          end
          PH_DRAIN: begin
            if (rx_valid) overflow <= 1'b1;
            if (take) begin
              if (count != '0) count <= count - 1'b1;
              else             append_delim <= 1'b0;
            end else if (tx_state == TX_IDLE && count == '0 && !append_delim) begin
              phase <= PH_FILL;
            end
          end
          default: phase <= PH_FILL;
        endcase
      end
    end
  end

  // Transmitter FSM with a registered tx output.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (take) begin
            tx_state <= TX_START;
            tx       <= 1'b0;
            tx_shift <= next_data;
            tx_cnt   <= '0;
          end
        end
        TX_START: begin
          if (tx_cnt == FULL_M1) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              tx_state <= TX_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (take) begin
              tx_state <= TX_START;
              tx       <= 1'b0;
              tx_shift <= next_data;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
